hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the five-stage RV32I pipeline; it drives the stall/flush controls of the IF/ID and ID/EX pipeline registers and the EX-stage operand forwarding muxes. It reads the register addresses and control bits that the ID/EX register presents in EX. It keeps its own shadow copies of the EX/MEM and MEM/WB destination information, so no extra pipeline-register outputs are needed. It also provides saturating stall/flush event counters for performance debug.

---
 rtl/hazard_if.sv | 19 +
 rtl/hazard_ctrl.sv | 48 ++++
 tb/tb_hazard_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: pipeline <-> hazard controller signal bundle.
// master is the pipeline side, slave is the hazard controller.
interface hazard_if #(parameter int CNT_W = 32);
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteE, PCSrcE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
    logic StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               RdM, RdW, RegWriteM, RegWriteW, stall_cnt, flush_cnt
    );
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               RdM, RdW, RegWriteM, RegWriteW, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I five-stage hazard/forwarding control with shadow EX/MEM,
// MEM/WB destination tracking and saturating stall/flush counters.
module hazard_ctrl #(parameter int CNT_W = 32) (
    input logic clk,
    input logic reset,
    hazard_if.slave h
);
    logic [4:0] rd_m, rd_w;
    logic rw_m, rw_w, lw_stall, stall;
    logic [CNT_W-1:0] stall_q, flush_q;
    // MEM result wins over WB so the youngest producer is used
    function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] dm,
                                       input logic wm, input logic [4:0] dw, input logic ww);
        return (rs != 5'd0 && wm && rs == dm) ? 2'b10 :
               (rs != 5'd0 && ww && rs == dw) ? 2'b01 : 2'b00;
    endfunction
    assign lw_stall = h.ResultSrcE == 2'b01 && h.RdE != 5'd0 &&
                      (h.Rs1D == h.RdE || h.Rs2D == h.RdE);
    assign stall = lw_stall && !h.PCSrcE;
    assign h.ForwardAE = fwd(h.Rs1E, rd_m, rw_m, rd_w, rw_w);
    assign h.ForwardBE = fwd(h.Rs2E, rd_m, rw_m, rd_w, rw_w);
    assign h.StallF = stall;
    assign h.StallD = stall;
    assign h.FlushD = h.PCSrcE;
    assign h.FlushE = lw_stall || h.PCSrcE;
    assign h.RdM = rd_m;
    assign h.RdW = rd_w;
    assign h.RegWriteM = rw_m;
    assign h.RegWriteW = rw_w;
    assign h.stall_cnt = stall_q;
    assign h.flush_cnt = flush_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rd_m <= '0;
            rd_w <= '0;
            rw_m <= 1'b0;
            rw_w <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            rd_m <= h.RdE;
            rw_m <= h.RegWriteE;
            rd_w <= rd_m;
            rw_w <= rw_m;
            if (stall && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
            if (h.PCSrcE && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
        end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, load-use stall, branch flush,
// reset behaviour and counter saturation (4-bit counters so saturation is reachable).
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int pass = 0;
    int total = 0;
    hazard_if #(.CNT_W(4)) h();
    hazard_ctrl #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .h(h));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic drive(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                         input logic rwe, input logic [1:0] rse, input logic pcs);
        h.Rs1D = rs1d; h.Rs2D = rs2d; h.Rs1E = rs1e; h.Rs2E = rs2e; h.RdE = rde;
        h.RegWriteE = rwe; h.ResultSrcE = rse; h.PCSrcE = pcs;
        #2;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        // reset with arbitrary operands and a load-use pattern present
        drive(5'd3, 5'($urandom), 5'($urandom), 5'($urandom), 5'd3, 1'b1, 2'b01, 1'b0);
        cyc(); cyc();
        chk("rst_rdm", h.RdM, 0);
        chk("rst_rdw", h.RdW, 0);
        chk("rst_rwm", h.RegWriteM, 0);
        chk("rst_rww", h.RegWriteW, 0);
        chk("rst_stallcnt", h.stall_cnt, 0);
        chk("rst_flushcnt", h.flush_cnt, 0);
        chk("rst_fwda", h.ForwardAE, 0);
        chk("rst_fwdb", h.ForwardBE, 0);
        chk("rst_stallf_follows", h.StallF, 1);
        chk("rst_flushe_follows", h.FlushE, 1);
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("rst_ctl_zero", {h.StallF, h.StallD, h.FlushD, h.FlushE}, 0);
        reset = 1'b0;
        // EX-to-EX then WB forwarding of x5
        drive(0, 0, 0, 0, 5'd5, 1, 2'b00, 0);
        chk("ex_noforward", h.ForwardAE, 0);
        cyc();
        drive(0, 0, 5'd5, 0, 0, 0, 2'b00, 0);
        chk("shadow_rdm", h.RdM, 5);
        chk("shadow_rwm", h.RegWriteM, 1);
        chk("fwdA_mem", h.ForwardAE, 2'b10);
        cyc();
        drive(0, 0, 0, 5'd5, 0, 0, 2'b00, 0);
        chk("shadow_rdw", h.RdW, 5);
        chk("fwdB_wb", h.ForwardBE, 2'b01);
        chk("fwdA_none", h.ForwardAE, 2'b00);
        // x7 in both MEM and WB shadows
        drive(0, 0, 0, 0, 5'd7, 1, 2'b00, 0);
        cyc(); cyc();
        drive(0, 0, 5'd7, 5'd7, 0, 0, 2'b00, 0);
        chk("prio_fwdA", h.ForwardAE, 2'b10);
        chk("prio_fwdB", h.ForwardBE, 2'b10);
        cyc();
        chk("wbonly_fwdA", h.ForwardAE, 2'b01);
        // load-use on rs2
        drive(0, 5'd3, 0, 0, 5'd3, 1, 2'b01, 0);
        chk("lu_ctl", {h.StallF, h.StallD, h.FlushD, h.FlushE}, 4'b1101);
        chk("lu_cnt0", h.stall_cnt, 0);
        cyc();
        drive(0, 5'd3, 0, 0, 0, 0, 2'b00, 0);
        chk("lu_cnt1", h.stall_cnt, 1);
        chk("lu_bubble_nostall", h.StallF, 0);
        cyc();
        drive(0, 0, 0, 5'd3, 0, 0, 2'b00, 0);
        chk("lu_fwdB_wb", h.ForwardBE, 2'b01);
        // load-use with taken branch in the same cycle
        drive(5'd4, 0, 0, 0, 5'd4, 1, 2'b01, 1);
        chk("sim_ctl", {h.StallF, h.StallD, h.FlushD, h.FlushE}, 4'b0011);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("sim_flushcnt", h.flush_cnt, 1);
        chk("sim_stallcnt", h.stall_cnt, 1);
        // long stall saturates the 4-bit counter
        drive(5'd2, 0, 0, 0, 5'd2, 1, 2'b01, 0);
        repeat (14) cyc();
        chk("sat_reach", h.stall_cnt, 4'hf);
        repeat (5) cyc();
        chk("sat_hold", h.stall_cnt, 4'hf);
        // x0 destination never forwards nor stalls
        drive(0, 0, 0, 0, 0, 1, 2'b01, 0);
        chk("x0_nostall", {h.StallF, h.FlushE}, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 1, 2'b00, 0);
        chk("x0_fwdA_mem", h.ForwardAE, 0);
        chk("x0_fwdB_mem", h.ForwardBE, 0);
        cyc();
        chk("x0_fwdA_wb", h.ForwardAE, 0);
        chk("x0_stallcnt_hold", h.stall_cnt, 4'hf);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
